// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator and its upstream feeder.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // The accumulator samples value this many cycles after its enable pulse.
    localparam int unsigned ACC_CAPTURE_LAT = 2;
    localparam int unsigned MIN_HOLD        = ACC_CAPTURE_LAT + 1;

endpackage

// File: rtl/accum_feeder_sync_fifo.sv
// Small synchronous FIFO with show-ahead output; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/accum_feeder.sv
// Feeds buffered words to the accumulator as 1-cycle enables, holding value
// through the capture window and spacing issues HOLD_CYCLES apart.
module accum_feeder
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     stall,
    output logic                     enable,
    output logic [DATA_W-1:0]        value,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         issued_count
);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    if (HOLD_CYCLES < MIN_HOLD) begin : g_hold_chk
        $error("accum_feeder: HOLD_CYCLES must cover the accumulator capture latency");
    end

    state_e             state_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               enable_q;
    logic               busy_q;
    logic [DATA_W-1:0]  value_q;
    logic [CNT_W-1:0]   issued_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_dout;
    logic               fifo_push;
    logic               issue_d;

    assign in_ready  = !fifo_full && !RST;
    assign fifo_push = in_valid && in_ready;

    // Issue decision points: any IDLE cycle, or the last HOLD cycle.
    assign issue_d = !RST && !fifo_empty && !stall &&
                     ((state_q == IDLE) || (state_q == HOLD && hold_q == '0));

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (issue_d),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            value_q  <= '0;
            issued_q <= '0;
        end else begin
            if (state_q == ISSUE) issued_q <= issued_q + CNT_W'(1);
            if (issue_d) begin
                state_q  <= ISSUE;
                enable_q <= 1'b1;
                busy_q   <= 1'b1;
                value_q  <= fifo_dout;
            end else begin
                enable_q <= 1'b0;
                unique case (state_q)
                    ISSUE: begin
                        state_q <= HOLD;
                        hold_q  <= HOLD_W'(HOLD_CYCLES - 2);
                        busy_q  <= 1'b1;
                    end
                    HOLD: begin
                        if (hold_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign enable       = enable_q;
    assign value        = value_q;
    assign busy         = busy_q;
    assign issued_count = issued_q;

endmodule

// File: doc/accum_feeder.md
Name: accum_feeder

Overview:
- Upstream stage for the 3-state accumulator (enable/value interface, led = count[23:16]).
- Buffers incoming 32-bit words from a valid/ready producer in a small FIFO.
- Issues each word as a 1-cycle enable pulse with value held stable for the accumulator's capture window.
- Spaces issues so that no enable lands while the accumulator is outside its idle state.

Parameters:
- DATA_W, 32, width of in_data and value.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- HOLD_CYCLES, 3, cycles value is held from the enable cycle onward; minimum 3, because the accumulator captures value 2 cycles after enable.
- CNT_W, 16, width of issued_count.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- in_valid  in  1  producer has a word.
- in_data  in  DATA_W  producer word.
- in_ready  out  1  feeder accepts the word this cycle.
- stall  in  1  suspends new issues; an in-flight hold always completes.
- enable  out  1  1-cycle issue pulse to the accumulator.
- value  out  DATA_W  word presented to the accumulator.
- busy  out  1  high in ISSUE or HOLD state.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- issued_count  out  CNT_W  number of enables issued; wraps.

Behaviour:
- Reset: RST, synchronous, active-high; clock CLK (posedge). On RST:
  - FIFO emptied; state=IDLE.
  - enable=0, value=0, busy=0, fifo_count=0, issued_count=0, in_ready=0 during the reset cycle.
  - Any in-flight word is discarded.
- Push: in_ready = !full and !RST, registered-consistent. A word is accepted when in_valid && in_ready at a posedge.
  - When full, no push is accepted, even if a pop occurs in the same cycle.
- Pop: a pop occurs only on the transition into ISSUE.
  - A pushed word is poppable at the earliest on the next cycle. Minimum latency from accept edge to enable=1 is 1 cycle.
- FSM states:
  - IDLE: if !empty && !stall, go to ISSUE at the next edge, pop the head, load value=head.
  - ISSUE: enable=1 for exactly this cycle; value stable; issued_count increments at the end of the cycle. Next state is HOLD; the hold counter loads HOLD_CYCLES-2.
  - HOLD: enable=0; value stable; the counter decrements. When the counter reaches 0:
    - if !empty && !stall, go directly to ISSUE (back-to-back);
    - otherwise go to IDLE.
- Spacing: consecutive enable pulses are exactly HOLD_CYCLES cycles apart when the FIFO stays non-empty. Default: enable at t, t+3, t+6, …
- value after hold: retains the last issued word until the next ISSUE loads a new one. Never changes during ISSUE or HOLD.
- stall:
  - Sampled only at the IDLE→ISSUE and HOLD→ISSUE decision points.
  - Asserting stall in ISSUE/HOLD does not shorten or extend the hold.
- Simultaneous push and pop: fifo_count is unchanged; order is strictly FIFO.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - issued_count wraps from 2^CNT_W-1 to 0.
- Reset mid-HOLD: enable never asserts in the reset cycle; the state machine restarts in IDLE next cycle.
- No data-dependent arithmetic on value; the feeder passes words bit-exact.

Decomposition:
- Shared package accum_pkg contains:
  - the state enum {IDLE, ISSUE, HOLD};
  - localparam ACC_CAPTURE_LAT=2;
  - localparam MIN_HOLD=ACC_CAPTURE_LAT+1.
- Elaboration check: HOLD_CYCLES >= MIN_HOLD.
- One sub-module, sync_fifo, parameterised by DATA_W and DEPTH:
  - ports: push, pop, din, dout, full, empty, count;
  - clocked by CLK, reset by RST.
- The FSM, hold counter and issued_count live in accum_feeder.

Test Plan:
1. Reset, then push one word 0x00010000 at cycle 5 → enable=1 at cycle 6 only; value=0x00010000 for cycles 6-8; issued_count=1. The downstream accumulator's led reads 0x01 after cycle 9.
2. Push 4 words 1, 2, 3, 4 on consecutive cycles → in_ready stays high (never full); enables at cycles t, t+3, t+6, t+9; value sequence 1, 2, 3, 4; accumulator count=10.
3. DEPTH=4: hold stall=1 and push 6 words → 4 accepted, in_ready=0 at fifo_count=4, producer back-pressured. Release stall → all 6 words eventually issue in order.
4. Assert stall during HOLD of word 0xA → the hold still lasts 3 cycles; the next enable is withheld until stall=0; value stays 0xA meanwhile.
5. Assert RST in the 2nd HOLD cycle with 2 words queued → the next cycle has enable=0, value=0, fifo_count=0, issued_count=0. No enable until a new word is pushed.
6. CNT_W=4: issue 17 words → issued_count reads 1 after the 17th. FIFO pointers wrap with no data corruption (values 1..17 arrive in order).
